// File: rtl/multi_dev_sweep_ctrl.sv
// Request-timing sweep engine: calibrates each device's solo req/ack latency, then sweeps
// the request offset of channels 1..N-1 against channel 0 and keeps the worst latency seen.
module multi_dev_sweep_ctrl #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned OFS_MAX = 32,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned STAGGER = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    output logic [NUM_CH-1:0]       dev_req_o,
    input  logic [NUM_CH-1:0]       dev_ack_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o,
    output logic [NUM_CH-1:0]       timeout_ch_o,
    output logic [CNT_W-1:0]        sweep_ofs_o,
    output logic [NUM_CH*CNT_W-1:0] base_lat_o,
    output logic [NUM_CH*CNT_W-1:0] worst_lat_o
);

    localparam int unsigned      IdxW    = $clog2(NUM_CH);
    localparam logic [CNT_W-1:0] TmoVal  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] OfsLast = CNT_W'(OFS_MAX);

    typedef enum logic [2:0] {StIdle, StCal, StSweep, StDone, StErr} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              active_q, active_d;
    logic [CNT_W-1:0]  ofs_q, ofs_d;
    logic [CNT_W-1:0]  rnd_q, rnd_d;
    logic [NUM_CH-1:0] req_q, req_d;
    logic [NUM_CH-1:0] fin_q, fin_d;
    logic [NUM_CH-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];
    logic [CNT_W-1:0]  base_q  [NUM_CH];
    logic [CNT_W-1:0]  base_d  [NUM_CH];
    logic [CNT_W-1:0]  worst_q [NUM_CH];
    logic [CNT_W-1:0]  worst_d [NUM_CH];

    logic [CNT_W-1:0]  cnt_inc [NUM_CH];
    logic [CNT_W-1:0]  lat     [NUM_CH];
    logic [NUM_CH-1:0] hs_end, hs_tmo;
    logic              cal_launch, rnd_launch;
    logic [CNT_W-1:0]  rnd_ofs;

    // Launch delay of channel k relative to the round edge, saturating at CNT_W bits.
    function automatic logic [CNT_W-1:0] ch_delay(input int unsigned k,
                                                  input logic [CNT_W-1:0] o);
        logic [2*CNT_W-1:0] prod;
        if (STAGGER == 0) begin
            return (k == 0) ? '0 : o;
        end
        prod = (2*CNT_W)'(k) * (2*CNT_W)'(o);
        return (|prod[2*CNT_W-1:CNT_W]) ? '1 : prod[CNT_W-1:0];
    endfunction

    // Per-channel handshake: count edges with req high; ack wins over timeout on the same edge.
    always_comb begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            cnt_inc[k] = (cnt_q[k] == '1) ? cnt_q[k] : cnt_q[k] + CNT_W'(1);
            lat[k]     = cnt_inc[k];
            hs_end[k]  = 1'b0;
            hs_tmo[k]  = 1'b0;
            if (req_q[k]) begin
                if (dev_ack_i[k]) begin
                    hs_end[k] = 1'b1;
                end else if (cnt_inc[k] >= TmoVal) begin
                    hs_end[k] = 1'b1;
                    hs_tmo[k] = 1'b1;
                    lat[k]    = TmoVal;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        active_d   = active_q;
        ofs_d      = ofs_q;
        rnd_d      = rnd_q;
        req_d      = req_q;
        fin_d      = fin_q;
        tmo_d      = tmo_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        worst_d    = worst_q;
        cal_launch = 1'b0;
        rnd_launch = 1'b0;
        rnd_ofs    = ofs_q;

        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (req_q[k]) begin
                if (hs_end[k]) begin
                    req_d[k] = 1'b0;
                    fin_d[k] = 1'b1;
                    tmo_d[k] = tmo_q[k] | hs_tmo[k];
                    if (state_q == StCal) begin
                        base_d[k] = lat[k];
                    end else if (lat[k] > worst_q[k]) begin
                        worst_d[k] = lat[k];
                    end
                end else begin
                    cnt_d[k] = cnt_inc[k];
                end
            end
        end

        case (state_q)
            StIdle, StDone, StErr: begin
                if (start_i) begin
                    state_d  = StCal;
                    idx_d    = '0;
                    active_d = 1'b0;
                    ofs_d    = '0;
                    rnd_d    = '0;
                    req_d    = '0;
                    fin_d    = '0;
                    tmo_d    = '0;
                    cnt_d    = '{default: '0};
                    base_d   = '{default: '0};
                    worst_d  = '{default: '0};
                end
            end
            StCal: begin
                if (!active_q) begin
                    active_d   = 1'b1;
                    cal_launch = 1'b1;
                end else if (fin_q[idx_q]) begin
                    if (|tmo_q) begin
                        state_d  = StErr;
                        active_d = 1'b0;
                    end else if (idx_q == IdxW'(NUM_CH - 1)) begin
                        state_d    = StSweep;
                        rnd_launch = 1'b1;
                        rnd_ofs    = '0;
                    end else begin
                        idx_d      = idx_q + IdxW'(1);
                        cal_launch = 1'b1;
                    end
                end
            end
            StSweep: begin
                if (&fin_q) begin
                    if (|tmo_q) begin
                        state_d  = StErr;
                        active_d = 1'b0;
                    end else if (ofs_q == OfsLast) begin
                        state_d  = StDone;
                        active_d = 1'b0;
                    end else begin
                        rnd_launch = 1'b1;
                        rnd_ofs    = ofs_q + CNT_W'(1);
                    end
                end else begin
                    rnd_d = (rnd_q == '1) ? rnd_q : rnd_q + CNT_W'(1);
                    for (int unsigned k = 0; k < NUM_CH; k++) begin
                        if (!req_q[k] && !fin_q[k] && rnd_q == ch_delay(k, ofs_q)) begin
                            req_d[k] = 1'b1;
                            cnt_d[k] = '0;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (cal_launch) begin
            fin_d        = '0;
            req_d[idx_d] = 1'b1;
            cnt_d[idx_d] = '0;
        end
        // Round edge: zero-delay channels launch now, the rest count off rnd_q.
        if (rnd_launch) begin
            fin_d = '0;
            ofs_d = rnd_ofs;
            rnd_d = CNT_W'(1);
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (ch_delay(k, rnd_ofs) == '0) begin
                    req_d[k] = 1'b1;
                    cnt_d[k] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            active_q <= 1'b0;
            ofs_q    <= '0;
            rnd_q    <= '0;
            req_q    <= '0;
            fin_q    <= '0;
            tmo_q    <= '0;
            cnt_q    <= '{default: '0};
            base_q   <= '{default: '0};
            worst_q  <= '{default: '0};
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            active_q <= active_d;
            ofs_q    <= ofs_d;
            rnd_q    <= rnd_d;
            req_q    <= req_d;
            fin_q    <= fin_d;
            tmo_q    <= tmo_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            worst_q  <= worst_d;
        end
    end

    assign dev_req_o    = req_q;
    assign busy_o       = (state_q == StCal) || (state_q == StSweep);
    assign done_o       = (state_q == StDone);
    assign error_o      = (state_q == StErr);
    assign timeout_ch_o = tmo_q;
    assign sweep_ofs_o  = ofs_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign base_lat_o[g*CNT_W +: CNT_W]  = base_q[g];
        assign worst_lat_o[g*CNT_W +: CNT_W] = worst_q[g];
    end

endmodule

// File: tb/tb_multi_dev_sweep_ctrl.sv
// Bench for multi_dev_sweep_ctrl: a 2-channel instance against a timeline reference model
// with randomized device latencies, plus a 4-channel staggered instance for launch offsets.
module tb_multi_dev_sweep_ctrl;

    localparam int NCH  = 2;
    localparam int OFS  = 4;
    localparam int TMO  = 16;
    localparam int CW   = 16;
    localparam int NREQ = OFS + 2;
    localparam int NB   = 4;
    localparam int OFSB = 3;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;

    logic [NCH-1:0]    req_a, ack_a, tmo_a;
    logic              busy_a, done_a, err_a;
    logic [CW-1:0]     ofs_a;
    logic [NCH*CW-1:0] base_a, worst_a;

    logic [NB-1:0]     req_b, ack_b, tmo_b;
    logic              busy_b, done_b, err_b;
    logic [CW-1:0]     ofs_b;
    logic [NB*CW-1:0]  base_b, worst_b;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    // Device model state for the 2-channel instance.
    int lat_tab [NCH][NREQ];
    int req_idx [NCH];
    int cur_lat [NCH];
    int n_hi [NCH];
    bit shared = 1'b0;
    int srv = -1;
    int srv_n = 0;
    int srv_lat [NCH] = '{3, 5};
    logic [NCH-1:0] prev_a = '0;
    int rise_a [NCH][$];
    int ofs_seen [$];

    int exp_rise [NCH][$];
    int exp_base [NCH];
    int exp_worst [NCH];
    bit exp_tmo [NCH];
    bit exp_err;
    int exp_end;

    logic [NB-1:0] prev_b = '0;
    int n_b [NB];
    int rise_b [NB][$];

    multi_dev_sweep_ctrl #(
        .NUM_CH(NCH), .CNT_W(CW), .OFS_MAX(OFS), .TIMEOUT(TMO), .STAGGER(0)
    ) u_dut_a (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_a),
        .dev_req_o(req_a), .dev_ack_i(ack_a),
        .busy_o(busy_a), .done_o(done_a), .error_o(err_a),
        .timeout_ch_o(tmo_a), .sweep_ofs_o(ofs_a),
        .base_lat_o(base_a), .worst_lat_o(worst_a)
    );

    multi_dev_sweep_ctrl #(
        .NUM_CH(NB), .CNT_W(CW), .OFS_MAX(OFSB), .TIMEOUT(TMO), .STAGGER(1)
    ) u_dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_b),
        .dev_req_o(req_b), .dev_ack_i(ack_b),
        .busy_o(busy_b), .done_o(done_b), .error_o(err_b),
        .timeout_ch_o(tmo_b), .sweep_ofs_o(ofs_b),
        .base_lat_o(base_b), .worst_lat_o(worst_b)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Devices respond on the falling edge; an ack raised after the n-th edge with req high
    // is sampled on edge n+1, so a device of latency L is seen L edges after req rises.
    always @(negedge clk_i) begin : dev_a
        for (int k = 0; k < NCH; k++) begin
            if (req_a[k] && !prev_a[k]) begin
                rise_a[k].push_back(cyc);
                if (k == 0) ofs_seen.push_back(int'(ofs_a));
                cur_lat[k] = (req_idx[k] < NREQ) ? lat_tab[k][req_idx[k]] : 1;
                req_idx[k]++;
            end
            prev_a[k] = req_a[k];
        end
        ack_a = '0;
        if (!shared) begin
            for (int k = 0; k < NCH; k++) begin
                n_hi[k] = req_a[k] ? n_hi[k] + 1 : 0;
                if (req_a[k] && n_hi[k] >= cur_lat[k]) ack_a[k] = 1'b1;
            end
        end else begin
            if (srv >= 0 && !req_a[srv]) srv = -1;
            if (srv < 0) begin
                for (int k = NCH - 1; k >= 0; k--) begin
                    if (req_a[k]) begin
                        srv   = k;
                        srv_n = 0;
                    end
                end
            end
            if (srv >= 0) begin
                srv_n++;
                if (srv_n >= srv_lat[srv]) ack_a[srv] = 1'b1;
            end
        end
    end

    always @(negedge clk_i) begin : dev_b
        for (int k = 0; k < NB; k++) begin
            if (req_b[k] && !prev_b[k]) rise_b[k].push_back(cyc);
            prev_b[k] = req_b[k];
            n_b[k] = req_b[k] ? n_b[k] + 1 : 0;
            ack_b[k] = req_b[k] && (n_b[k] >= 2);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int eff(input int l);
        return (l > TMO) ? TMO : l;
    endfunction

    // Timeline of one run from the start edge s, derived from the handshake and round rules.
    task automatic model_a(input int s);
        int t, t0, d, l, fin, mx;
        bit err;
        for (int k = 0; k < NCH; k++) begin
            exp_base[k]  = 0;
            exp_worst[k] = 0;
            exp_tmo[k]   = 1'b0;
            exp_rise[k].delete();
        end
        err = 1'b0;
        t = s + 1;
        for (int k = 0; k < NCH; k++) begin
            if (!err) begin
                exp_rise[k].push_back(t);
                l = eff(lat_tab[k][0]);
                exp_base[k] = l;
                if (lat_tab[k][0] > TMO) begin
                    exp_tmo[k] = 1'b1;
                    err = 1'b1;
                end
                t = t + l + 1;
            end
        end
        for (int o = 0; o <= OFS; o++) begin
            if (!err) begin
                t0 = t;
                mx = 0;
                for (int k = 0; k < NCH; k++) begin
                    d = k * o;
                    exp_rise[k].push_back(t0 + d);
                    l = eff(lat_tab[k][o + 1]);
                    fin = t0 + d + l;
                    if (fin > mx) mx = fin;
                    if (l > exp_worst[k]) exp_worst[k] = l;
                    if (lat_tab[k][o + 1] > TMO) begin
                        exp_tmo[k] = 1'b1;
                        err = 1'b1;
                    end
                end
                t = mx + 1;
            end
        end
        exp_end = t;
        exp_err = err;
    endtask

    task automatic run_a(input bit use_model);
        int s, waited, n;
        for (int k = 0; k < NCH; k++) begin
            rise_a[k].delete();
            req_idx[k] = 0;
        end
        ofs_seen.delete();
        @(negedge clk_i);
        start_a = 1'b1;
        s = cyc + 1;
        @(negedge clk_i);
        start_a = 1'b0;
        check_eq("busy_after_start", busy_a, 1);
        check_eq("flags_cleared", {done_a, err_a}, 0);
        if (use_model) model_a(s);
        waited = 0;
        while (!(done_a || err_a) && waited < 3000) begin
            @(negedge clk_i);
            waited++;
        end
        check_eq("run_ends", done_a | err_a, 1);
        check_eq("busy_at_end", busy_a, 0);
        if (use_model) begin
            check_eq("end_edge", cyc - s, exp_end - s);
            check_eq("error", err_a, exp_err);
            check_eq("done", done_a, !exp_err);
            for (int k = 0; k < NCH; k++) begin
                check_eq($sformatf("base%0d", k), base_a[k*CW +: CW], exp_base[k]);
                check_eq($sformatf("worst%0d", k), worst_a[k*CW +: CW], exp_worst[k]);
                check_eq($sformatf("tmo%0d", k), tmo_a[k], exp_tmo[k]);
                check_eq($sformatf("nrise%0d", k), rise_a[k].size(), exp_rise[k].size());
                n = (rise_a[k].size() < exp_rise[k].size()) ? rise_a[k].size()
                                                             : exp_rise[k].size();
                for (int i = 0; i < n; i++) begin
                    check_eq($sformatf("rise%0d_%0d", k, i), rise_a[k][i] - s,
                             exp_rise[k][i] - s);
                end
            end
        end
    endtask

    task automatic check_a_zero(input string pfx);
        check_eq({pfx, "_req"}, req_a, 0);
        check_eq({pfx, "_flags"}, {busy_a, done_a, err_a}, 0);
        check_eq({pfx, "_tmo"}, tmo_a, 0);
        check_eq({pfx, "_ofs"}, ofs_a, 0);
        check_eq({pfx, "_base"}, base_a, 0);
        check_eq({pfx, "_worst"}, worst_a, 0);
    endtask

    task automatic fill_const(input int l0, input int l1);
        for (int i = 0; i < NREQ; i++) begin
            lat_tab[0][i] = l0;
            lat_tab[1][i] = l1;
        end
    endtask

    initial begin
        int waited, r;
        fill_const(3, 5);
        #2 rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        check_a_zero("rst");
        check_eq("rst_b_ctl", {req_b, busy_b, done_b, err_b, tmo_b, ofs_b}, 0);
        check_eq("rst_b_lat", {base_b, worst_b}, 0);
        rst_ni = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            check_eq("idle_req", {req_a, req_b, busy_a}, 0);
        end

        // Independent devices, latencies 3 and 5.
        run_a(1'b1);
        check_eq("t2_base", base_a, 32'h0005_0003);
        check_eq("t2_worst", worst_a, 32'h0005_0003);
        check_eq("t2_done", done_a, 1);
        check_eq("t2_nofs", ofs_seen.size(), OFS + 2);
        for (int i = 1; i < ofs_seen.size() && i < OFS + 2; i++) begin
            check_eq($sformatf("t2_ofs%0d", i), ofs_seen[i], i - 1);
        end

        // ch1 never acknowledges.
        fill_const(3, 100);
        run_a(1'b1);
        check_eq("t4_tmo", tmo_a, 2'b10);
        check_eq("t4_base1", base_a[CW +: CW], 16);
        check_eq("t4_flags", {err_a, done_a, busy_a}, 3'b100);

        // One shared server, ch0 served first.
        shared = 1'b1;
        run_a(1'b0);
        check_eq("t3_worst", worst_a, 32'h0008_0003);
        check_eq("t3_base", base_a, 32'h0005_0003);
        check_eq("t3_done", done_a, 1);
        shared = 1'b0;

        // Randomized latencies, occasionally at or past the timeout.
        for (int it = 0; it < 8; it++) begin
            for (int k = 0; k < NCH; k++) begin
                for (int i = 0; i < NREQ; i++) begin
                    r = $urandom_range(0, 29);
                    if (r == 0) lat_tab[k][i] = $urandom_range(17, 20);
                    else if (r == 1) lat_tab[k][i] = 16;
                    else lat_tab[k][i] = $urandom_range(1, 12);
                end
            end
            run_a(1'b1);
        end

        // Start during sweep is ignored; reset mid-round clears everything at once.
        fill_const(3, 5);
        for (int k = 0; k < NCH; k++) req_idx[k] = 0;
        @(negedge clk_i);
        start_a = 1'b1;
        @(negedge clk_i);
        start_a = 1'b0;
        waited = 0;
        while (ofs_a != 2 && waited < 500) begin
            @(negedge clk_i);
            waited++;
        end
        check_eq("t6_reach_ofs2", ofs_a, 2);
        start_a = 1'b1;
        @(negedge clk_i);
        start_a = 1'b0;
        check_eq("t6_busy", busy_a, 1);
        check_eq("t6_ofs", ofs_a, 2);
        check_eq("t6_base", base_a, 32'h0005_0003);
        waited = 0;
        while (req_a == 0 && waited < 50) begin
            @(negedge clk_i);
            waited++;
        end
        check_eq("t6_req_live", req_a != 0, 1);
        rst_ni = 1'b0;
        #1;
        check_a_zero("t6_rst");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        run_a(1'b1);
        check_eq("t6_worst", worst_a, 32'h0005_0003);

        // Staggered 4-channel launch offsets: ch k rises k*o after ch0.
        for (int k = 0; k < NB; k++) rise_b[k].delete();
        @(negedge clk_i);
        start_b = 1'b1;
        @(negedge clk_i);
        start_b = 1'b0;
        waited = 0;
        while (!(done_b || err_b) && waited < 2000) begin
            @(negedge clk_i);
            waited++;
        end
        check_eq("t5_done", done_b, 1);
        for (int k = 0; k < NB; k++) begin
            check_eq($sformatf("t5_nrise%0d", k), rise_b[k].size(), OFSB + 2);
            check_eq($sformatf("t5_worst%0d", k), worst_b[k*CW +: CW], 2);
        end
        for (int o = 0; o <= OFSB; o++) begin
            for (int k = 1; k < NB; k++) begin
                if (rise_b[k].size() > o + 1 && rise_b[0].size() > o + 1) begin
                    check_eq($sformatf("t5_delta_o%0d_ch%0d", o, k),
                             rise_b[k][o + 1] - rise_b[0][o + 1], k * o);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
